// File: rtl/byte_stream_pkg.sv
// ============================================================================
// byte_stream_pkg : shared constants and types for the byte-stream receiver
// Rev 1.0
// ============================================================================
`default_nettype none

package byte_stream_pkg;

  localparam int C_DATA_W = 8;
  localparam int C_DEPTH  = 4;

  typedef logic [C_DATA_W-1:0] beat_t;

  // Pointer width for a FIFO of the given depth; a single entry still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_stream_fifo_mem.sv
// ============================================================================
// byte_stream_fifo_mem : DEPTH x DATA_W register array, sync write, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module byte_stream_fifo_mem
  import byte_stream_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int DEPTH  = C_DEPTH,
  parameter int PTR_W  = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/byte_stream_receiver.sv
// ============================================================================
// byte_stream_receiver : captures a no-backpressure byte stream into a FIFO
// and re-presents it on a ready/valid port with a sticky overflow flag. Rev 1.0
// ============================================================================
`default_nettype none

module byte_stream_receiver
  import byte_stream_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int DEPTH  = C_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  level,
  output logic              overflow,
  input  logic              clear_ovf
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W-1:0]  r_wptr;
  logic [CNT_W-1:0]  r_level;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_overflow;

  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_we;
  logic [PTR_W-1:0]  w_rptr_nxt;
  logic [PTR_W-1:0]  w_wptr_nxt;
  logic [CNT_W-1:0]  w_level_nxt;
  logic [CNT_W-1:0]  w_remain;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_head_nxt;

  assign w_full = (r_level == CNT_W'(DEPTH));
  assign w_pop  = r_out_valid & out_ready;
  assign w_push = in_valid & (~w_full | w_pop);
  assign w_drop = in_valid & w_full & ~w_pop;
  assign w_we   = w_push & reset;

  // Entries left after this cycle's pop; zero means the beat being written
  // right now becomes the new head, so it is taken from in_data directly.
  assign w_remain = r_level - {{(CNT_W-1){1'b0}}, w_pop};

  always_comb begin
    w_rptr_nxt  = w_pop  ? r_rptr + PTR_W'(1) : r_rptr;
    w_wptr_nxt  = w_push ? r_wptr + PTR_W'(1) : r_wptr;
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - CNT_W'(1);
    end
    w_head_nxt = (w_push && (w_remain == '0)) ? in_data : w_mem_rdata;
  end

  byte_stream_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (in_data),
    .i_raddr (w_rptr_nxt),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rptr      <= '0;
      r_wptr      <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_rptr      <= w_rptr_nxt;
      r_wptr      <= w_wptr_nxt;
      r_level     <= w_level_nxt;
      r_out_valid <= (w_level_nxt != '0);
      if (w_level_nxt != '0) begin
        r_out_data <= w_head_nxt;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign level     = r_level;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_byte_stream_receiver.sv
// ============================================================================
// tb_byte_stream_receiver : directed stimulus with a queue scoreboard and an
// independent negedge monitor for the byte_stream_receiver. Rev 1.0
// ============================================================================
`default_nettype none

module tb_byte_stream_receiver;
  import byte_stream_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  beat_t            in_data;
  logic             in_valid;
  beat_t            out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] level;
  logic             overflow;
  logic             clear_ovf;

  int    checks   = 0;
  int    failures = 0;
  beat_t sb[$];
  int    m_level  = 0;
  bit    m_ovf    = 1'b0;

  byte_stream_receiver #(
    .DATA_W (8),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat offered while ready is high is consumed at the next edge.
  bit    prev_stall = 1'b0;
  beat_t prev_data;
  always @(negedge clk) begin
    if (prev_stall && out_valid) begin
      chk("stall_hold", int'(out_data), int'(prev_data));
    end
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", int'(out_data), -1);
      end else begin
        chk("out_data", int'(out_data), int'(sb.pop_front()));
      end
    end
    prev_stall = reset && out_valid && !out_ready;
    prev_data  = out_data;
  end

  // Drive one cycle of inputs, update the reference model, check after the edge.
  task automatic step(input logic rst_n, input logic v, input beat_t d,
                      input logic rdy, input logic clr);
    bit pop, push, drop;
    reset = rst_n; in_valid = v; in_data = d; out_ready = rdy; clear_ovf = clr;
    pop  = rdy && (m_level != 0);
    push = v && ((m_level < DEPTH) || pop);
    drop = v && (m_level == DEPTH) && !pop;
    if (!rst_n) begin
      m_level = 0;
      m_ovf   = 1'b0;
      sb.delete();
    end else begin
      if (push) sb.push_back(d);
      m_level = m_level + int'(push) - int'(pop);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("level", int'(level), m_level);
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("out_valid", int'(out_valid), int'(m_level != 0));
  endtask

  task automatic drain();
    int n = 0;
    while (m_level != 0 && n < 20) begin
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      n++;
    end
    chk("drain_done", m_level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_ovf = 1'b0;

    // Reset held with junk input, then idle
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("reset_out_data", int'(out_data), 0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);

    // Single beat, show-ahead after one edge
    step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("single_data", int'(out_data), 8'hA5);
    chk("single_level", int'(level), 1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_empty", int'(out_valid), 0);

    // Fill and overflow: 05 is dropped
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, beat_t'(i), 1'b0, 1'b0);
    chk("fill_level", int'(level), 4);
    chk("fill_ovf", int'(overflow), 1);
    drain();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("fill_ovf_clr", int'(overflow), 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, beat_t'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h14, 1'b1, 1'b0);
    chk("pushpop_level", int'(level), 4);
    chk("pushpop_ovf", int'(overflow), 0);
    chk("pushpop_head", int'(out_data), 8'h11);
    drain();

    // Continuous stream with toggling ready, across pointer wrap
    idx = 0;
    for (int cyc = 0; cyc < 60 && (idx < 12 || m_level != 0); cyc++) begin
      logic rdy, v;
      rdy = (cyc % 2 == 0);
      v   = (idx < 12) && ((m_level < DEPTH) || (rdy && m_level != 0));
      step(1'b1, v, beat_t'(8'h20 + idx), rdy, 1'b0);
      if (v) idx++;
    end
    chk("stream_count", idx, 12);
    chk("stream_ovf", int'(overflow), 0);
    drain();

    // Clear racing a drop: set wins, then a lone clear takes effect
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, beat_t'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b1);
    chk("race_ovf", int'(overflow), 1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("race_clr", int'(overflow), 0);
    drain();

    // Reset mid-burst empties the FIFO and ignores beats
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_data", int'(out_data), 0);
    step(1'b1, 1'b1, 8'h88, 1'b0, 1'b0);
    chk("post_rst_head", int'(out_data), 8'h88);
    drain();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/byte_stream_receiver.md
Name: byte_stream_receiver

Overview:
Receiving end of the 8-bit registered data/valid stream produced by upstream byte-stream sources. Upstream has no backpressure, so every beat presented with valid high must be captured or counted as lost. Beats are buffered in a small FIFO and re-presented on a downstream ready/valid interface. A sticky overflow flag reports dropped beats.

Parameters:
DATA_W, 8, width of each data beat
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  input  1  single clock; all logic on its rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
in_data  input  DATA_W  upstream data beat
in_valid  input  1  upstream beat qualifier; no ready returned upstream
out_data  output  DATA_W  head-of-FIFO data
out_valid  output  1  head entry present
out_ready  input  1  downstream accepts head this cycle
level  output  CNT_W  current FIFO occupancy, 0..DEPTH
overflow  output  1  sticky: at least one beat dropped since reset/clear
clear_ovf  input  1  one-cycle pulse that clears overflow

Behaviour:
- Reset (reset==0 at a clk edge): out_valid=0, out_data=0, level=0, overflow=0. Read/write pointers return to 0. Any buffered beats are discarded. reset dominates all other inputs that cycle.
- Push: in_valid==1 and (level<DEPTH, or pop occurring the same cycle). The beat is written at the write pointer, which advances.
- Pop: out_valid==1 and out_ready==1. The head is consumed and the read pointer advances.
- Drop: in_valid==1, level==DEPTH, no pop that cycle. The beat is discarded and overflow is set the next cycle. FIFO contents and level are unchanged.
- Simultaneous push+pop: level unchanged. When full, both succeed and no overflow occurs.
- level update: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH and never underflows.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from level, not from pointer comparison.
- Output is show-ahead: out_data is always the entry at the read pointer.
  - out_valid = (level != 0), registered.
- Latency: a beat pushed into an empty FIFO at edge N is visible at out_data/out_valid after edge N; the first pop is possible at edge N+1. There is no bypass from in_data to out_data.
- out_data holds its last value when out_valid==0. Its value is don't-care for checking except after reset, where it is 0.
- out_valid/out_data rules:
  - out_valid may fall only when the last entry is popped.
  - out_data must not change while out_valid==1 and out_ready==0.
- overflow set/clear:
  - Set by any drop. Cleared by clear_ovf.
  - If a drop and clear_ovf occur in the same cycle, the set wins and overflow stays 1.
- in_valid==0 with arbitrary in_data has no effect.
- Reset mid-burst: the FIFO empties immediately. Beats presented during reset are ignored and do not set overflow.

Decomposition:
- Shared package byte_stream_pkg:
  - DATA_W default constant.
  - typedef logic [DATA_W-1:0] beat_t.
  - Helper constant for pointer width.
- One natural sub-module, byte_stream_fifo_mem: a DEPTH x DATA_W register array with a write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata).
- Pointer, level and flag control stay in byte_stream_receiver.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles with in_valid=1, in_data=8'hFF, then release. Required: out_valid=0, level=0, overflow=0 throughout.
- Single beat: push 8'hA5 at edge N with out_ready=0. Required: after edge N, out_valid=1, out_data=8'hA5, level=1. Raise out_ready for one cycle; after the next edge, out_valid=0, level=0.
- Fill and overflow: out_ready=0, push 8'h01..8'h05 on 5 consecutive cycles with DEPTH=4. Required: level=4 and overflow=1 after the 5th edge. Draining yields 01,02,03,04 in order, and 05 never appears.
- Full with simultaneous push+pop: fill with 10..13, then one cycle with in_valid=1, in_data=8'h14, out_ready=1. Required: level stays 4, overflow stays 0, drain order is 11,12,13,14.
- Stall stability and wrap: stream 8'h20..8'h2B continuously with out_ready toggling 1,0,1,0. Required: out_data is stable during every stall, all 12 values arrive in order across pointer wrap, and overflow=0.
- Overflow clear race: with the FIFO full, assert clear_ovf and a dropped push in the same cycle. Required: overflow=1. Then pulse clear_ovf alone; required: overflow=0 after that edge.
